mem_dir_ctrl: RTL and testbench
===============================

MEM_DIR_CTRL -- requirements
Module: mem_dir_ctrl

Interface
REQ-001 SHALL have parameter MBITS, default 24: log2 of main-memory size in 32-bit words.
REQ-002 SHALL have parameter PRESET_LINES, default 128: number of low lines initialised to MODIFIED.
REQ-003 SHALL have port clock, input, 1: the single clock.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port RingIn, input, 32: ring payload from the last core.
REQ-006 SHALL have port SlotTypeIn, input, 4: slot type from the last core.
REQ-007 SHALL have port SourceIn, input, 4: originating core.
REQ-008 SHALL have port mem_addr, output, MBITS: word address to main memory.
REQ-009 SHALL have port mem_we, output, 1: memory write strobe.
REQ-010 SHALL have port mem_wdata, output, 32: memory write data.
REQ-011 SHALL have port mem_rdata, input, 32: read data, valid one cycle after mem_addr.
REQ-012 SHALL have port RDreturn, output, 32: read-data bus head.
REQ-013 SHALL have port RDdest, output, 4: read-data destination; 0 means idle.
REQ-014 SHALL have port rq_wr, output, 1: resend-queue push.
REQ-015 SHALL have port rq_din, output, 40: resend entry {dest, type, payload}.
REQ-016 SHALL have port rq_full, input, 1: resend queue full.
REQ-017 SHALL have port init_done, output, 1: directory sweep complete.
REQ-018 SHALL have port err, output, 3: sticky flags {bad address, md overflow, ma overflow}.

Function
REQ-019 SHALL push {SourceIn, RingIn} into the ma FIFO (512 deep) when SlotTypeIn==Address, and RingIn into the md FIFO (4096 deep) when SlotTypeIn==WriteData.
REQ-020 SHALL decode address bits as: [31] retry, [30] ownership-only, [29] exclusive, [28] read (1) / write (0), [27:0] line number.
REQ-021 SHALL hold a 2-bit directory entry per line (CLEAN=0, WAITING=1, MODIFIED=2) for 2^(MBITS-3) lines.
REQ-022 SHALL use FSM states INIT, IDLE, SEND, WRITE; it SHALL not pop either FIFO in INIT.
REQ-023 In INIT it SHALL write one directory entry per cycle (MODIFIED for lines < PRESET_LINES, else CLEAN), then assert init_done and go to IDLE.
REQ-024 In IDLE with ma non-empty and line bits [27:MBITS-3] nonzero, it SHALL pop, drop the request and set err[2].
REQ-025 A read SHALL be possible iff dir==CLEAN, or dir==WAITING and retry=1.
REQ-026 A possible read SHALL set dir to MODIFIED if exclusive, else CLEAN.
REQ-027 If ownership-only, a possible read SHALL push {dest,4'b0110,4'b0000,addr[27:0]} and pop.
REQ-028 Otherwise, a possible read SHALL enter SEND without popping.
REQ-029 An impossible read SHALL push {dest,4'b0010,2'b10,addr[29:0]}, leave dir unchanged and pop.
REQ-030 Any IDLE action that needs a push SHALL stall entirely (no pop, no dir update) while rq_full=1.
REQ-031 A write with md non-empty SHALL set dir to WAITING if exclusive, else CLEAN, and enter WRITE.
REQ-032 SEND SHALL issue words 0..7 of the line on consecutive cycles.
REQ-033 RDreturn/RDdest SHALL be registered from mem_rdata, giving first data 2 cycles after word 0 is issued; the ma pop and the return to IDLE SHALL occur on word 7.
REQ-034 WRITE SHALL advance the word counter and pulse mem_we only when md is non-empty, holding while it is empty, and SHALL pop ma on word 7.
REQ-035 SHALL set err[1]/err[0] on a push to a full md/ma FIFO; the push is dropped.

Reset
REQ-036 On reset low, SHALL go to state INIT with line counter 0 and word counter 0, and SHALL drive RDreturn=0, RDdest=0, rq_wr=0, mem_we=0, init_done=0 and err=0.
REQ-037 SHALL flush both FIFOs on reset; reset mid-burst SHALL abort the burst with no further RDreturn words.

Structure
REQ-038 SHALL take slot-type codes, directory encodings, address-bit positions and resend type codes from shared package beehive_mem_pkg.
REQ-039 SHALL instantiate the existing parameterised fifo sub-module twice (ma, md); the directory is an internal RAM array.

Verification
REQ-040 Read at line 200 (CLEAN), dest 3 -> 8 words mem[1600..1607] on RDreturn with RDdest=3, then dir[200]=CLEAN.
REQ-041 Read at line 5 after init (MODIFIED) -> rq_din={3,4'b0010,2'b10,addr[29:0]} and no RDreturn.
REQ-042 Exclusive write at line 300 with 8 md words -> mem written and dir=WAITING; retry read -> data returned and dir CLEAN or MODIFIED per the exclusive bit.
REQ-043 Ownership-only exclusive read of a CLEAN line with rq_full=1 for 10 cycles -> no pop for those cycles, then exactly one push of type 4'b0110 and dir=MODIFIED.
REQ-044 Write with md supplying words with 3-cycle gaps -> exactly 8 mem_we pulses in order and the ma pop on word 7.
REQ-045 Reset asserted during SEND word 4 -> RDdest=0 immediately, INIT sweep restarts and init_done reasserts.

Source files
------------

// File: rtl/beehive_mem_pkg.sv
// Shared encodings for the Beehive memory directory controller: ring slot
// types, directory states, request address fields and resend-queue types.
package beehive_mem_pkg;

  localparam logic [3:0] SLOT_ADDRESS   = 4'h2;
  localparam logic [3:0] SLOT_WRITEDATA = 4'h3;

  localparam int ADDR_RETRY_BIT = 31;
  localparam int ADDR_OWN_BIT   = 30;
  localparam int ADDR_EXCL_BIT  = 29;
  localparam int ADDR_READ_BIT  = 28;
  localparam int ADDR_LINE_MSB  = 27;

  localparam logic [3:0] RQ_TYPE_OWNER = 4'b0110;
  localparam logic [3:0] RQ_TYPE_FAIL  = 4'b0010;
  localparam logic [1:0] RQ_FAIL_TAG   = 2'b10;

  localparam int MA_DEPTH = 512;
  localparam int MD_DEPTH = 4096;

  typedef enum logic [1:0] {
    DIR_CLEAN    = 2'd0,
    DIR_WAITING  = 2'd1,
    DIR_MODIFIED = 2'd2
  } dir_state_t;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_SEND,
    ST_WRITE
  } ctrl_state_t;

  typedef struct packed {
    logic [3:0]  dest;
    logic [3:0]  rtype;
    logic [31:0] payload;
  } rq_entry_t;

  function automatic dir_state_t dir_after_read(input logic excl);
    return excl ? DIR_MODIFIED : DIR_CLEAN;
  endfunction

  function automatic dir_state_t dir_after_write(input logic excl);
    return excl ? DIR_WAITING : DIR_CLEAN;
  endfunction

endpackage

// File: rtl/mem_dir_ctrl_fifo.sv
// Show-ahead synchronous FIFO; head word is visible on dout while not empty.
// Pushes to a full FIFO and pops of an empty FIFO are ignored.
module mem_dir_ctrl_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] ram [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = ram[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) ram[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mem_dir_ctrl.sv
// Memory directory controller: queues ring address/write-data slots, tracks a
// 2-bit coherence state per 8-word line and streams line reads/writes to memory.
module mem_dir_ctrl
  import beehive_mem_pkg::*;
#(
  parameter int MBITS        = 24,
  parameter int PRESET_LINES = 128
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      RingIn,
  input  logic [3:0]       SlotTypeIn,
  input  logic [3:0]       SourceIn,
  output logic [MBITS-1:0] mem_addr,
  output logic             mem_we,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic [31:0]      RDreturn,
  output logic [3:0]       RDdest,
  output logic             rq_wr,
  output logic [39:0]      rq_din,
  input  logic             rq_full,
  output logic             init_done,
  output logic [2:0]       err
);

  localparam int LW     = MBITS - 3;
  localparam int NLINES = 1 << LW;

  logic        ma_push, ma_pop, ma_empty, ma_full;
  logic [35:0] ma_dout;
  logic        md_push, md_pop, md_empty, md_full;
  logic [31:0] md_dout;

  assign ma_push = (SlotTypeIn == SLOT_ADDRESS);
  assign md_push = (SlotTypeIn == SLOT_WRITEDATA);

  mem_dir_ctrl_fifo #(.DATA_W(36), .DEPTH(MA_DEPTH)) u_ma_fifo (
    .clock (clock),
    .reset (reset),
    .push  (ma_push),
    .din   ({SourceIn, RingIn}),
    .pop   (ma_pop),
    .dout  (ma_dout),
    .empty (ma_empty),
    .full  (ma_full)
  );

  mem_dir_ctrl_fifo #(.DATA_W(32), .DEPTH(MD_DEPTH)) u_md_fifo (
    .clock (clock),
    .reset (reset),
    .push  (md_push),
    .din   (RingIn),
    .pop   (md_pop),
    .dout  (md_dout),
    .empty (md_empty),
    .full  (md_full)
  );

  ctrl_state_t state, state_nx;
  logic [LW-1:0] line_cnt;
  logic [2:0]    word_cnt, word_cnt_nx;

  dir_state_t    dir_ram [NLINES];
  logic          dir_we;
  logic [LW-1:0] dir_waddr;
  dir_state_t    dir_wdata;

  logic [31:0]   hd_addr;
  logic [3:0]    hd_src;
  logic [LW-1:0] hd_line;
  logic          hd_bad;
  dir_state_t    hd_dir;
  logic          rd_ok;

  logic          rq_push;
  rq_entry_t     rq_entry;
  logic          bad_set;
  logic          vld_p0;
  logic          vld_p1;
  logic [3:0]    dest_p1;

  assign hd_addr = ma_dout[31:0];
  assign hd_src  = ma_dout[35:32];
  assign hd_line = hd_addr[LW-1:0];
  assign hd_bad  = (hd_addr[ADDR_LINE_MSB:0] >> LW) != '0;
  assign hd_dir  = dir_ram[hd_line];
  assign rd_ok   = (hd_dir == DIR_CLEAN) ||
                   ((hd_dir == DIR_WAITING) && hd_addr[ADDR_RETRY_BIT]);

  always_comb begin
    state_nx    = state;
    word_cnt_nx = word_cnt;
    ma_pop      = 1'b0;
    md_pop      = 1'b0;
    dir_we      = 1'b0;
    dir_waddr   = hd_line;
    dir_wdata   = DIR_CLEAN;
    rq_push     = 1'b0;
    rq_entry    = '0;
    bad_set     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = {hd_line, word_cnt};
    mem_wdata   = md_dout;
    vld_p0      = 1'b0;
    case (state)
      ST_INIT: begin
        dir_we    = 1'b1;
        dir_waddr = line_cnt;
        dir_wdata = (int'(line_cnt) < PRESET_LINES) ? DIR_MODIFIED : DIR_CLEAN;
        if (line_cnt == '1) state_nx = ST_IDLE;
      end
      ST_IDLE: begin
        if (!ma_empty) begin
          if (hd_bad) begin
            ma_pop  = 1'b1;
            bad_set = 1'b1;
          end else if (hd_addr[ADDR_READ_BIT]) begin
            if (rd_ok && !hd_addr[ADDR_OWN_BIT]) begin
              dir_we    = 1'b1;
              dir_wdata = dir_after_read(hd_addr[ADDR_EXCL_BIT]);
              state_nx  = ST_SEND;
            end else if (!rq_full) begin
              // Both remaining read outcomes answer through the resend queue.
              rq_push = 1'b1;
              ma_pop  = 1'b1;
              if (rd_ok) begin
                dir_we    = 1'b1;
                dir_wdata = dir_after_read(hd_addr[ADDR_EXCL_BIT]);
                rq_entry  = {hd_src, RQ_TYPE_OWNER, 4'b0000, hd_addr[ADDR_LINE_MSB:0]};
              end else begin
                rq_entry  = {hd_src, RQ_TYPE_FAIL, RQ_FAIL_TAG, hd_addr[ADDR_EXCL_BIT:0]};
              end
            end
          end else if (!md_empty) begin
            dir_we    = 1'b1;
            dir_wdata = dir_after_write(hd_addr[ADDR_EXCL_BIT]);
            state_nx  = ST_WRITE;
          end
        end
      end
      ST_SEND: begin
        vld_p0      = 1'b1;
        word_cnt_nx = word_cnt + 3'd1;
        if (word_cnt == 3'd7) begin
          ma_pop   = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (!md_empty) begin
          mem_we      = 1'b1;
          md_pop      = 1'b1;
          word_cnt_nx = word_cnt + 3'd1;
          if (word_cnt == 3'd7) begin
            ma_pop   = 1'b1;
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_INIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_INIT;
      line_cnt  <= '0;
      word_cnt  <= '0;
      init_done <= 1'b0;
      err       <= '0;
      rq_wr     <= 1'b0;
      vld_p1    <= 1'b0;
      RDreturn  <= '0;
      RDdest    <= '0;
    end else begin
      state    <= state_nx;
      word_cnt <= word_cnt_nx;
      if (state == ST_INIT) line_cnt <= line_cnt + LW'(1);
      if ((state == ST_INIT) && (state_nx == ST_IDLE)) init_done <= 1'b1;
      err    <= err | {bad_set, md_push && md_full, ma_push && ma_full};
      rq_wr  <= rq_push;
      // Stage p0 issues the address; memory answers during p1; p2 drives the head.
      vld_p1   <= vld_p0;
      RDreturn <= vld_p1 ? mem_rdata : '0;
      RDdest   <= vld_p1 ? dest_p1 : '0;
    end
  end

  always_ff @(posedge clock) begin
    dest_p1 <= hd_src;
    if (rq_push) rq_din <= rq_entry;
    if (dir_we)  dir_ram[dir_waddr] <= dir_wdata;
  end

endmodule

// File: tb/tb_mem_dir_ctrl.sv
// Directed bench for mem_dir_ctrl with a small memory (MBITS=12, 512 lines).
module tb_mem_dir_ctrl;
  import beehive_mem_pkg::*;

  localparam int MBITS = 12;

  logic             clock = 1'b0;
  logic             reset;
  logic [31:0]      RingIn;
  logic [3:0]       SlotTypeIn;
  logic [3:0]       SourceIn;
  logic [MBITS-1:0] mem_addr;
  logic             mem_we;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;
  logic [31:0]      RDreturn;
  logic [3:0]       RDdest;
  logic             rq_wr;
  logic [39:0]      rq_din;
  logic             rq_full;
  logic             init_done;
  logic [2:0]       err;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [1 << MBITS];
  logic [35:0] rd_q [$];
  logic [39:0] rq_q [$];
  logic [63:0] we_q [$];

  mem_dir_ctrl #(.MBITS(MBITS), .PRESET_LINES(128)) dut (
    .clock      (clock),
    .reset      (reset),
    .RingIn     (RingIn),
    .SlotTypeIn (SlotTypeIn),
    .SourceIn   (SourceIn),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .RDreturn   (RDreturn),
    .RDdest     (RDdest),
    .rq_wr      (rq_wr),
    .rq_din     (rq_din),
    .rq_full    (rq_full),
    .init_done  (init_done),
    .err        (err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always @(negedge clock) begin
    if (reset && RDdest != 4'd0) rd_q.push_back({RDdest, RDreturn});
    if (reset && rq_wr)          rq_q.push_back(rq_din);
    if (reset && mem_we)         we_q.push_back({32'(mem_addr), mem_wdata});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic logic [31:0] mk_addr(input logic r, input logic o, input logic e,
                                          input logic rd, input int line);
    return {r, o, e, rd, 28'(line)};
  endfunction

  task automatic send_addr(input logic [3:0] src, input logic [31:0] a);
    SlotTypeIn = SLOT_ADDRESS;
    SourceIn   = src;
    RingIn     = a;
    tick();
    SlotTypeIn = 4'h0;
    SourceIn   = 4'h0;
    RingIn     = '0;
  endtask

  task automatic send_wd(input logic [31:0] d);
    SlotTypeIn = SLOT_WRITEDATA;
    RingIn     = d;
    tick();
    SlotTypeIn = 4'h0;
    RingIn     = '0;
  endtask

  task automatic wait_init(input string tag);
    for (int i = 0; i < 2000 && !init_done; i++) tick();
    check(tag, 64'(init_done), 64'd1);
  endtask

  task automatic check_line(input string tag, input logic [3:0] dest, input int base,
                            input logic [31:0] first);
    check({tag, "_count"}, 64'(rd_q.size()), 64'd8);
    for (int k = 0; k < 8 && k < rd_q.size(); k++) begin
      check({tag, "_data"}, 64'(rd_q[k][31:0]), 64'(first + 32'(k)));
      check({tag, "_dest"}, 64'(rd_q[k][35:32]), 64'(dest));
    end
    if (base < 0) check({tag, "_base"}, 64'(base), 64'd0);
  endtask

  initial begin
    int found;
    int n_after;
    reset      = 1'b0;
    RingIn     = '0;
    SlotTypeIn = 4'h0;
    SourceIn   = 4'h0;
    rq_full    = 1'b0;
    for (int i = 0; i < (1 << MBITS); i++) mem[i] = 32'hA500_0000 + 32'(i);

    tick(3);
    check("rst_RDdest", 64'(RDdest), 64'd0);
    check("rst_RDreturn", 64'(RDreturn), 64'd0);
    check("rst_rq_wr", 64'(rq_wr), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_init_done", 64'(init_done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    reset = 1'b1;
    tick(100);
    check("init_mid_sweep", 64'(init_done), 64'd0);
    wait_init("init_done");

    // Clean line read, then a second plain read shows the line stayed CLEAN.
    send_addr(4'd3, mk_addr(0, 0, 0, 1, 200));
    tick(30);
    check_line("rd200", 4'd3, 0, 32'hA500_0640);
    check("rd200_no_rq", 64'(rq_q.size()), 64'd0);
    rd_q.delete();
    send_addr(4'd4, mk_addr(0, 0, 0, 1, 200));
    tick(30);
    check("rd200_again_count", 64'(rd_q.size()), 64'd8);
    if (rd_q.size() > 0) check("rd200_again_dest", 64'(rd_q[0][35:32]), 64'd4);
    rd_q.delete();

    // Preset MODIFIED line refuses the read.
    send_addr(4'd3, mk_addr(0, 0, 0, 1, 5));
    tick(20);
    check("rd5_rq_count", 64'(rq_q.size()), 64'd1);
    if (rq_q.size() > 0) check("rd5_rq_din", 64'(rq_q[0]), 64'h32_9000_0005);
    check("rd5_no_data", 64'(rd_q.size()), 64'd0);
    rq_q.delete();

    // Exclusive write leaves WAITING; plain read fails, retry read succeeds.
    send_addr(4'd2, mk_addr(0, 0, 1, 0, 300));
    for (int k = 0; k < 8; k++) send_wd(32'hD000_0000 + 32'(k));
    tick(20);
    check("wr300_count", 64'(we_q.size()), 64'd8);
    for (int k = 0; k < 8 && k < we_q.size(); k++)
      check("wr300_word", we_q[k], {32'(2400 + k), 32'hD000_0000 + 32'(k)});
    we_q.delete();
    send_addr(4'd6, mk_addr(0, 0, 0, 1, 300));
    tick(20);
    check("rd300_wait_rq", 64'(rq_q.size()), 64'd1);
    if (rq_q.size() > 0) check("rd300_wait_din", 64'(rq_q[0]), 64'h62_9000_012C);
    rq_q.delete();
    send_addr(4'd5, mk_addr(1, 0, 0, 1, 300));
    tick(30);
    check_line("rd300_retry", 4'd5, 0, 32'hD000_0000);
    rd_q.delete();
    send_addr(4'd5, mk_addr(0, 0, 0, 1, 300));
    tick(30);
    check("rd300_clean_count", 64'(rd_q.size()), 64'd8);
    rd_q.delete();

    // Ownership-only exclusive read stalls behind a full resend queue.
    rq_full = 1'b1;
    send_addr(4'd7, mk_addr(0, 1, 1, 1, 400));
    tick(10);
    check("own400_stall", 64'(rq_q.size()), 64'd0);
    rq_full = 1'b0;
    tick(10);
    check("own400_count", 64'(rq_q.size()), 64'd1);
    if (rq_q.size() > 0) check("own400_din", 64'(rq_q[0]), 64'h76_0000_0190);
    check("own400_no_data", 64'(rd_q.size()), 64'd0);
    rq_q.delete();
    send_addr(4'd8, mk_addr(0, 0, 0, 1, 400));
    tick(20);
    check("rd400_mod_rq", 64'(rq_q.size()), 64'd1);
    if (rq_q.size() > 0) check("rd400_mod_din", 64'(rq_q[0]), 64'h82_9000_0190);
    rq_q.delete();

    // Gappy write data; the queued read must wait for the write's last word.
    send_addr(4'd1, mk_addr(0, 0, 0, 0, 450));
    send_addr(4'd9, mk_addr(0, 0, 0, 1, 200));
    for (int k = 0; k < 8; k++) begin
      if (k == 7) check("wr450_no_early_pop", 64'(rd_q.size()), 64'd0);
      send_wd(32'hE000_0000 + 32'(k));
      tick(3);
    end
    tick(30);
    check("wr450_count", 64'(we_q.size()), 64'd8);
    for (int k = 0; k < 8 && k < we_q.size(); k++)
      check("wr450_word", we_q[k], {32'(3600 + k), 32'hE000_0000 + 32'(k)});
    check_line("rd200_after_wr", 4'd9, 0, 32'hA500_0640);
    we_q.delete();
    rd_q.delete();
    send_addr(4'd2, mk_addr(0, 0, 0, 1, 450));
    tick(30);
    check_line("rd450", 4'd2, 0, 32'hE000_0000);
    rd_q.delete();

    // Line number beyond the directory.
    send_addr(4'd3, mk_addr(0, 0, 0, 1, 512));
    tick(20);
    check("bad_err", 64'(err), 64'd4);
    check("bad_no_data", 64'(rd_q.size()), 64'd0);
    check("bad_no_rq", 64'(rq_q.size()), 64'd0);

    // Reset in the middle of a burst.
    send_addr(4'd3, mk_addr(0, 0, 0, 1, 200));
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      @(negedge clock);
      if (mem_addr == MBITS'(1604)) found = 1;
    end
    check("burst_word4_seen", 64'(found), 64'd1);
    reset = 1'b0;
    #1;
    check("rstmid_RDdest", 64'(RDdest), 64'd0);
    check("rstmid_RDreturn", 64'(RDreturn), 64'd0);
    check("rstmid_init_done", 64'(init_done), 64'd0);
    check("rstmid_err", 64'(err), 64'd0);
    n_after = rd_q.size();
    tick(3);
    reset = 1'b1;
    tick(20);
    check("rstmid_no_more_data", 64'(rd_q.size()), 64'(n_after));
    check("rstmid_sweep_restart", 64'(init_done), 64'd0);
    wait_init("rstmid_init_done_again");
    check("rstmid_no_data_final", 64'(rd_q.size()), 64'(n_after));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
